// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with a one-word output holding
// register, valid/ready handoff, frame alignment and a sticky overrun flag.
module sipo_deser #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             frame_start,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_q, shift_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             valid_q, valid_n;
  logic             ovr_q, ovr_n;

  logic [WIDTH-1:0] shift_base;
  logic [CW-1:0]    cnt_base;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             ovr_set;

  // Next-state: alignment, bit assembly, output handoff and overrun tracking
  always_comb begin
    shift_n  = shift_q;
    cnt_n    = cnt_q;
    data_n   = data_q;
    valid_n  = valid_q;
    ovr_n    = ovr_q;
    ovr_set  = 1'b0;
    complete = 1'b0;

    // frame_start discards the partial word before this edge's bit is taken
    shift_base = frame_start ? '0 : shift_q;
    cnt_base   = frame_start ? '0 : cnt_q;
    shifted    = (shift_base << 1) | WIDTH'(sin);

    if (sin_en) begin
      shift_n = shifted;
      if (cnt_base == CW'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_n    = '0;
      end else begin
        cnt_n    = cnt_base + CW'(1);
      end
    end else begin
      shift_n = shift_base;
      cnt_n   = cnt_base;
    end

    if (complete) begin
      if (!valid_q || ready) begin
        data_n  = shifted;
        valid_n = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_n = 1'b0;
    end

    // A new overrun on the same edge outranks the clear request
    if (ovr_set) begin
      ovr_n = 1'b1;
    end else if (clr_ovr) begin
      ovr_n = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
    end
  end

  // Output mapping; busy is decoded directly from the bit counter
  always_comb begin
    data    = data_q;
    valid   = valid_q;
    overrun = ovr_q;
    busy    = (cnt_q != '0);
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4).
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       frame_start;
  logic       ready;
  logic       clr_ovr;
  logic [3:0] data;
  logic       valid;
  logic       busy;
  logic       overrun;

  int passed = 0;
  int total  = 0;

  sipo_deser #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .sin_en      (sin_en),
    .frame_start (frame_start),
    .ready       (ready),
    .clr_ovr     (clr_ovr),
    .data        (data),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it
  task automatic step(input logic s, input logic en, input logic fs,
                      input logic rdy, input logic clr);
    sin         = s;
    sin_en      = en;
    frame_start = fs;
    ready       = rdy;
    clr_ovr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_en = 1'b0; frame_start = 1'b0;
    ready = 1'b0; clr_ovr = 1'b0;
    #2;
    chk("rst_data", 8'(data), 8'h0);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_ovr", 8'(overrun), 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic word 1011 -> B
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b_busy1", 8'(busy), 8'h1);
    chk("b_valid1", 8'(valid), 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b_busy2", 8'(busy), 8'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b_busy3", 8'(busy), 8'h1);
    chk("b_valid3", 8'(valid), 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b_data", 8'(data), 8'hB);
    chk("b_valid4", 8'(valid), 8'h1);
    chk("b_busy4", 8'(busy), 8'h0);
    idle(1'b1);
    chk("b_valid_drop", 8'(valid), 8'h0);

    // Continuous stream 1010_0110 -> A then 6
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s_data_a", 8'(data), 8'hA);
    chk("s_valid_a", 8'(valid), 8'h1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s_valid_gap", 8'(valid), 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s_data_6", 8'(data), 8'h6);
    chk("s_valid_6", 8'(valid), 8'h1);
    chk("s_ovr", 8'(overrun), 8'h0);
    idle(1'b1);

    // Back-to-back with ready held: completion and accept on same edge
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bb_data_d", 8'(data), 8'hD);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bb_data_2", 8'(data), 8'h2);
    chk("bb_valid_2", 8'(valid), 8'h1);
    chk("bb_ovr", 8'(overrun), 8'h0);
    idle(1'b1);

    // Overrun: 5 held with ready=0, 9 dropped; set wins over clr
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("o_data_5", 8'(data), 8'h5);
    chk("o_ovr0", 8'(overrun), 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("o_data_hold", 8'(data), 8'h5);
    chk("o_valid_hold", 8'(valid), 8'h1);
    chk("o_ovr_set_wins", 8'(overrun), 8'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("o_ovr_clr", 8'(overrun), 8'h0);
    chk("o_data_after_clr", 8'(data), 8'h5);
    chk("o_valid_after_clr", 8'(valid), 8'h1);
    idle(1'b1);
    chk("o_valid_consumed", 8'(valid), 8'h0);

    // Gapped strobes 1,1,0,0 -> C
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("g_busy_gap", 8'(busy), 8'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("g_valid_early", 8'(valid), 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("g_data_c", 8'(data), 8'hC);
    chk("g_valid", 8'(valid), 8'h1);
    idle(1'b1);

    // frame_start with strobe: partial 11 discarded, then 0,0,1,1 -> 3
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("f_busy", 8'(busy), 8'h1);
    chk("f_valid", 8'(valid), 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f_valid_early", 8'(valid), 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f_data_3", 8'(data), 8'h3);
    chk("f_valid_3", 8'(valid), 8'h1);

    // frame_start without strobe: counter clears, valid/data untouched
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fn_busy", 8'(busy), 8'h0);
    chk("fn_data", 8'(data), 8'h3);
    chk("fn_valid", 8'(valid), 8'h1);
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fn_data_9", 8'(data), 8'h9);
    idle(1'b1);

    // Async reset mid-word while valid=1, then 0,1,1,1 -> 7
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("r_data_e", 8'(data), 8'hE);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("r_busy_pre", 8'(busy), 8'h1);
    sin_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("r_valid", 8'(valid), 8'h0);
    chk("r_data", 8'(data), 8'h0);
    chk("r_busy", 8'(busy), 8'h0);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("r_valid_b1", 8'(valid), 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("r_data_7", 8'(data), 8'h7);
    chk("r_valid_7", 8'(valid), 8'h1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
